nibble_serial_adder: RTL

Multi-cycle WIDTH-bit adder that streams operands one nibble per clock through the existing `fourbitadder` stage and assembles its `Sum`/`Cout` into a full-width result. It sits directly around the 4-bit adder as both its feeder and its consumer:
- it latches wide operands and presents nibble `i` plus the registered carry;
- it captures `Sum`/`Cout` back into the result register.

Start/done handshake to the surrounding datapath.

---
 rtl/nsa_pkg.sv | 13 +
 rtl/fourbitadder.sv | 16 +
 rtl/nibble_serial_adder.sv | 110 +++++++++++
 3 files changed

// File: rtl/nsa_pkg.sv
// nsa_pkg: shared types and constants for the nibble-serial adder.
//   nsa_state_t : control FSM states (IDLE, RUN)
//   NIBBLE_W    : width of one adder slice
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } nsa_state_t;

endpackage

// File: rtl/fourbitadder.sv
// fourbitadder: combinational 4-bit ripple adder slice.
//   A, B : 4-bit operands
//   Cin  : carry in
//   Sum  : 4-bit sum
//   Cout : carry out
module fourbitadder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that streams one nibble per clock
// through a single fourbitadder slice and assembles the full result.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request, sampled only while idle (latches A, B, Cin)
//   A, B, Cin : operands and carry in
//   busy      : nibbles in flight
//   done      : one-cycle pulse when Sum/Cout/overflow are valid
//   Sum, Cout : registered result; Cout is bit WIDTH of A+B+Cin
//   overflow  : two's-complement overflow of the full-width add
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int LSBW    = $clog2(WIDTH);

    nsa_state_t       state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [LSBW-1:0]  lsb;
    logic             last;

    logic [NIBBLE_W-1:0] add_sum;
    logic                add_cout;

    // Bit offset of the current nibble; nibble width is a power of two so
    // this is just the index shifted left.
    assign lsb  = LSBW'({idx, {$clog2(NIBBLE_W){1'b0}}});
    assign last = (idx == IDXW'(NIBBLES - 1));

    fourbitadder u_add (
        .A    (a_q[lsb +: NIBBLE_W]),
        .B    (b_q[lsb +: NIBBLE_W]),
        .Cin  (carry),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Sum      <= '0;
            Cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        carry    <= Cin;
                        idx      <= '0;
                        Sum      <= '0;
                        Cout     <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    Sum[lsb +: NIBBLE_W] <= add_sum;
                    carry                <= add_cout;
                    idx                  <= idx + 1'b1;
                    if (last) begin
                        // On the last nibble add_sum[MSB] is the new result MSB.
                        Cout     <= add_cout;
                        overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                    (add_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
